// File: rtl/score_bram_step_scheduler.sv
// Round-robin share of one score BRAM port among diffusion engines,
// with a global step barrier that advances l_step once all engines finish.
module score_bram_step_scheduler #(
  parameter int NUM_ENG    = 4,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STEPS  = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_ENG-1:0]            eng_req,
  input  logic [NUM_ENG-1:0]            eng_we,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr,
  input  logic [NUM_ENG*DATA_WIDTH-1:0] eng_wdata,
  input  logic [NUM_ENG-1:0]            eng_done,
  output logic [NUM_ENG-1:0]            eng_rdy,
  output logic [NUM_ENG-1:0]            eng_conflict,
  output logic [NUM_ENG-1:0]            eng_rvalid,
  output logic [DATA_WIDTH-1:0]         eng_rdata,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic                          bram_we,
  output logic [DATA_WIDTH-1:0]         bram_wdata,
  input  logic [DATA_WIDTH-1:0]         bram_rdata,
  output logic [DATA_WIDTH-1:0]         l_step,
  output logic                          busy,
  output logic                          all_done
);

  localparam int PW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SYNC,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [PW-1:0]           r_rr;
  logic [NUM_ENG-1:0]      r_done;
  logic [NUM_ENG-1:0]      r_rvalid;
  logic [DATA_WIDTH-1:0]   r_step;
  logic [ADDR_WIDTH-1:0]   r_addr;

  logic                    w_run;
  logic [NUM_ENG-1:0]      w_elig;
  logic [NUM_ENG-1:0]      w_gnt;
  logic                    w_found;
  logic [PW-1:0]           w_gidx;
  logic [PW-1:0]           w_rr_nxt;
  logic                    w_gwe;
  logic                    w_barrier;
  int                      w_idx;

  assign w_run     = (r_state == S_RUN);
  assign w_elig    = eng_req & {NUM_ENG{w_run}} & ~r_done;
  assign w_barrier = &(r_done | eng_done);

  // first eligible engine at or after the round-robin pointer
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_ENG; k++) begin
      w_idx = int'(r_rr) + k;
      if (w_idx >= NUM_ENG) w_idx = w_idx - NUM_ENG;
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = PW'(w_idx);
      end
    end
  end

  assign w_gnt    = w_found ? (NUM_ENG'(1) << w_gidx) : '0;
  assign w_gwe    = w_found & eng_we[w_gidx];
  assign w_rr_nxt = (w_gidx == PW'(NUM_ENG - 1)) ? '0 : w_gidx + 1'b1;

  assign bram_addr  = w_found ? eng_addr[w_gidx*ADDR_WIDTH +: ADDR_WIDTH]
                              : r_addr;
  assign bram_we    = w_gwe;
  assign bram_wdata = w_found ? eng_wdata[w_gidx*DATA_WIDTH +: DATA_WIDTH]
                              : '0;

  assign eng_rdy      = {NUM_ENG{w_run}};
  assign eng_conflict = w_elig & ~w_gnt;
  assign eng_rvalid   = r_rvalid;
  assign eng_rdata    = bram_rdata;
  assign l_step       = r_step;
  assign busy         = (r_state == S_RUN) || (r_state == S_SYNC);
  assign all_done     = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rr     <= '0;
      r_done   <= '0;
      r_rvalid <= '0;
      r_step   <= '0;
      r_addr   <= '0;
    end else begin
      r_rvalid <= w_gnt & ~eng_we;
      if (w_found) begin
        r_rr   <= w_rr_nxt;
        r_addr <= bram_addr;
      end
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_step  <= '0;
            r_done  <= '0;
          end
        end
        S_RUN: begin
          r_done <= r_done | eng_done;
          if (w_barrier) r_state <= S_SYNC;
        end
        S_SYNC: begin
          r_done <= '0;
          if (r_step == DATA_WIDTH'(MAX_STEPS - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_step  <= r_step + 1'b1;
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_bram_step_scheduler.sv
// Scoreboard bench for score_bram_step_scheduler: stimulus pushes expected
// read returns, a negedge monitor pops them on eng_rvalid.
module tb_score_bram_step_scheduler;

  localparam int NE = 4;
  localparam int AW = 13;
  localparam int DW = 32;

  typedef struct packed {
    logic [NE-1:0] v;
    logic [DW-1:0] d;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [NE-1:0]     eng_req;
  logic [NE-1:0]     eng_we;
  logic [NE*AW-1:0]  eng_addr;
  logic [NE*DW-1:0]  eng_wdata;
  logic [NE-1:0]     eng_done;
  logic [NE-1:0]     eng_rdy;
  logic [NE-1:0]     eng_conflict;
  logic [NE-1:0]     eng_rvalid;
  logic [DW-1:0]     eng_rdata;
  logic [AW-1:0]     bram_addr;
  logic              bram_we;
  logic [DW-1:0]     bram_wdata;
  logic [DW-1:0]     bram_rdata;
  logic [DW-1:0]     l_step;
  logic              busy;
  logic              all_done;

  logic [AW-1:0]     addr_a [NE];
  logic [DW-1:0]     wd_a   [NE];
  logic [DW-1:0]     mem    [0:(1<<AW)-1];

  exp_t              sb[$];
  int                nchk = 0;
  int                nerr = 0;

  score_bram_step_scheduler #(
    .NUM_ENG(NE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STEPS(7)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .eng_req(eng_req), .eng_we(eng_we),
    .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_done(eng_done), .eng_rdy(eng_rdy),
    .eng_conflict(eng_conflict), .eng_rvalid(eng_rvalid),
    .eng_rdata(eng_rdata), .bram_addr(bram_addr),
    .bram_we(bram_we), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata), .l_step(l_step),
    .busy(busy), .all_done(all_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    eng_addr  = '0;
    eng_wdata = '0;
    for (int i = 0; i < NE; i++) begin
      eng_addr[i*AW +: AW]  = addr_a[i];
      eng_wdata[i*DW +: DW] = wd_a[i];
    end
  end

  // score BRAM: synchronous read, one cycle latency
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_wdata;
    bram_rdata <= mem[bram_addr];
  end

  function automatic logic [AW-1:0] ea(input int i);
    return AW'(13'h100 + i * 3);
  endfunction

  function automatic logic [DW-1:0] pre(input logic [AW-1:0] a);
    return 32'h5A00_0000 | DW'(a);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (eng_rvalid !== '0) begin
      nchk++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL rvalid_unexpected got=%b exp=none", eng_rvalid);
      end else begin
        e = sb.pop_front();
        if (eng_rvalid !== e.v || eng_rdata !== e.d) begin
          nerr++;
          $display("FAIL rd_return got=%b/%h exp=%b/%h",
                   eng_rvalid, eng_rdata, e.v, e.d);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic push(input logic [NE-1:0] v, input logic [DW-1:0] d);
    exp_t e;
    e.v = v;
    e.d = d;
    sb.push_back(e);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int syncs;
    bit fin;
    for (int a = 0; a < (1 << AW); a++) mem[a] = pre(AW'(a));
    for (int i = 0; i < NE; i++) begin
      addr_a[i] = ea(i);
      wd_a[i]   = 32'hD0 + DW'(i);
    end
    rst_n = 1'b0; start = 1'b0;
    eng_req = '0; eng_we = '0; eng_done = '0;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    settle;
    chk("rst_l_step", l_step, 0);
    chk("rst_rdy", DW'(eng_rdy), 0);
    chk("rst_we", DW'(bram_we), 0);
    chk("rst_all_done", DW'(all_done), 0);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_addr", DW'(bram_addr), 0);
    chk("rst_rvalid", DW'(eng_rvalid), 0);

    start = 1'b1;
    tick;
    start = 1'b0;
    settle;
    chk("run_busy", DW'(busy), 1);
    chk("run_rdy", DW'(eng_rdy), 32'hF);

    for (int k = 0; k < 5; k++) begin
      g = k % NE;
      eng_req = 4'hF;
      settle;
      chk("rr_addr", DW'(bram_addr), DW'(ea(g)));
      chk("rr_conflict", DW'(eng_conflict), DW'(4'hF & ~(4'b1 << g)));
      chk("rr_we", DW'(bram_we), 0);
      push(4'b1 << g, pre(ea(g)));
      tick;
    end

    eng_req = 4'b0100; eng_we = 4'b0100;
    addr_a[2] = 13'h015; wd_a[2] = 32'hA0;
    settle;
    chk("wr_we", DW'(bram_we), 1);
    chk("wr_addr", DW'(bram_addr), 32'h15);
    chk("wr_wdata", bram_wdata, 32'hA0);
    chk("wr_conflict", DW'(eng_conflict), 0);
    tick;
    eng_req = '0; eng_we = '0;
    addr_a[2] = ea(2); wd_a[2] = 32'hD2;
    settle;
    chk("wr_no_rvalid", DW'(eng_rvalid), 0);
    chk("idle_addr_hold", DW'(bram_addr), 32'h15);
    chk("idle_we", DW'(bram_we), 0);
    tick;
    eng_req = 4'b0001; addr_a[0] = 13'h015;
    settle;
    push(4'b0001, 32'hA0);
    tick;
    eng_req = '0; addr_a[0] = ea(0);
    tick;

    for (int c = 0; c <= 27; c++) begin
      eng_req = '0; eng_we = '0; eng_done = '0;
      case (c)
        10: eng_done = 4'b0001;
        14: begin eng_done = 4'b0010; eng_req = 4'b0011; end
        20: eng_done = 4'b0100;
        25: eng_done = 4'b1000;
        26: eng_req = 4'hF;
        27: eng_req = 4'b0001;
        default: ;
      endcase
      settle;
      if (c <= 25) chk("bar_rdy", DW'(eng_rdy), 32'hF);
      if (c == 14) begin
        chk("mask_conflict", DW'(eng_conflict), 0);
        chk("mask_addr", DW'(bram_addr), DW'(ea(1)));
        push(4'b0010, pre(ea(1)));
      end
      if (c == 26) begin
        chk("sync_rdy", DW'(eng_rdy), 0);
        chk("sync_conflict", DW'(eng_conflict), 0);
        chk("sync_busy", DW'(busy), 1);
        chk("sync_l_step", l_step, 0);
      end
      if (c == 27) begin
        chk("resume_rdy", DW'(eng_rdy), 32'hF);
        chk("resume_l_step", l_step, 1);
        chk("sync_no_rvalid", DW'(eng_rvalid), 0);
        chk("resume_addr", DW'(bram_addr), DW'(ea(0)));
        chk("resume_conflict", DW'(eng_conflict), 0);
        push(4'b0001, pre(ea(0)));
      end
      tick;
    end
    eng_req = '0; eng_done = '0;

    syncs = 0;
    fin = 1'b0;
    for (int k = 0; k < 100 && !fin; k++) begin
      eng_done = (eng_rdy == 4'hF) ? 4'hF : 4'h0;
      settle;
      if (busy && eng_rdy == 4'h0) syncs++;
      if (all_done) fin = 1'b1;
      else tick;
    end
    eng_done = '0;
    if (!fin) begin
      nchk++; nerr++;
      $display("FAIL full_run_timeout got=busy exp=all_done");
    end
    chk("sync_total", DW'(syncs + 1), 7);
    chk("done_l_step", l_step, 6);
    chk("done_all_done", DW'(all_done), 1);
    chk("done_busy", DW'(busy), 0);
    chk("done_rdy", DW'(eng_rdy), 0);

    start = 1'b1;
    tick;
    start = 1'b0;
    settle;
    chk("restart_l_step", l_step, 0);
    chk("restart_busy", DW'(busy), 1);
    chk("restart_all_done", DW'(all_done), 0);

    fin = 1'b0;
    for (int k = 0; k < 50 && !fin; k++) begin
      if (l_step == 3 && eng_rdy == 4'hF) begin
        fin = 1'b1;
      end else begin
        eng_done = (eng_rdy == 4'hF) ? 4'hF : 4'h0;
        tick;
      end
    end
    eng_done = '0;
    if (!fin) begin
      nchk++; nerr++;
      $display("FAIL reach_step3_timeout got=%0d exp=3", l_step);
    end

    eng_req = 4'hF;
    settle;
    chk("mid_addr", DW'(bram_addr), DW'(ea(1)));
    push(4'b0010, pre(ea(1)));
    tick;
    rst_n = 1'b0;
    eng_we = 4'hF;
    settle;
    tick;
    settle;
    chk("mid_rst_l_step", l_step, 0);
    chk("mid_rst_we", DW'(bram_we), 0);
    chk("mid_rst_rvalid", DW'(eng_rvalid), 0);
    chk("mid_rst_rdy", DW'(eng_rdy), 0);
    chk("mid_rst_busy", DW'(busy), 0);
    chk("mid_rst_addr", DW'(bram_addr), 0);
    rst_n = 1'b1;
    eng_req = '0; eng_we = '0;
    repeat (3) tick;
    chk("sb_drained", DW'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/score_bram_step_scheduler.md
Name: score_bram_step_scheduler

Overview:
- Shares one score-table BRAM port among NUM_ENG diffusion random-walk engines.
- Arbitrates per cycle, round-robin, and drives each engine's conflict/rdy.
- Sequences global diffusion steps: l_step advances only after every engine has finished the current step (step barrier).
- Sits between the engines and the score BRAM, under PS control via start.

Parameters:
- NUM_ENG, 4, number of engines sharing the score BRAM port (2..8)
- ADDR_WIDTH, 13, score BRAM address width
- DATA_WIDTH, 32, score word width and l_step width
- MAX_STEPS, 7, number of diffusion steps to run (l_step 0..MAX_STEPS-1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- eng_req  in  NUM_ENG  per-engine access request
- eng_we  in  NUM_ENG  per-engine write enable (valid with eng_req)
- eng_addr  in  NUM_ENG*ADDR_WIDTH  packed addresses; engine i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- eng_wdata  in  NUM_ENG*DATA_WIDTH  packed write data
- eng_done  in  NUM_ENG  engine finished its share of the current step
- eng_rdy  out  NUM_ENG  engine enabled to run the current step
- eng_conflict  out  NUM_ENG  1 = request not granted this cycle; engine must hold and retry
- eng_rvalid  out  NUM_ENG  one-hot; eng_rdata belongs to this engine's read from the previous cycle
- eng_rdata  out  DATA_WIDTH  broadcast read data (= bram_rdata)
- bram_addr  out  ADDR_WIDTH  to score BRAM
- bram_we  out  1  to score BRAM
- bram_wdata  out  DATA_WIDTH  to score BRAM
- bram_rdata  in  DATA_WIDTH  from score BRAM; synchronous read, 1-cycle latency
- l_step  out  DATA_WIDTH  current diffusion step
- busy  out  1  high in RUN or SYNC
- all_done  out  1  high in DONE

Behaviour:
- Reset (rst_n=0 at a clk edge), taking effect mid-run as well:
  - state=IDLE; l_step=0; rr_ptr=0; done_seen=0; eng_rvalid=0.
  - Combinational outputs then resolve to: eng_rdy=0, eng_conflict=0, bram_we=0, bram_addr=0, bram_wdata=0, busy=0, all_done=0.
- States:
  - IDLE: start -> RUN, l_step=0.
  - RUN: eng_rdy all 1; arbitration active. When done_seen | eng_done is all ones -> SYNC.
  - SYNC: exactly 1 cycle; eng_rdy=0; no grants. Clear done_seen.
    - If l_step==MAX_STEPS-1 -> DONE (l_step held).
    - Else l_step+1 -> RUN.
  - DONE: all_done=1, eng_rdy=0. start -> RUN with l_step=0 and done_seen cleared. start is ignored in RUN/SYNC.
- done_seen: sticky per engine, set by eng_done in RUN. An engine with done_seen=1 keeps rdy=1, but its requests are masked (no grant, no conflict).
- Arbitration (combinational, RUN only):
  - Eligible = eng_req & eng_rdy & ~done_seen.
  - Grant = first eligible index searching rr_ptr, rr_ptr+1, ... modulo NUM_ENG.
  - Granted engine's addr/we/wdata are muxed onto bram_*.
  - No grant: bram_we=0; bram_addr holds its last value.
  - eng_conflict[i] = eligible[i] & ~grant[i].
  - On a grant, rr_ptr <= grant index + 1 (wraps NUM_ENG-1 -> 0); otherwise rr_ptr is unchanged.
- Read return: eng_rvalid <= grant & ~we, registered, so it arrives one cycle after the grant, aligned with bram_rdata. eng_rvalid is 0 the cycle after a write or an idle cycle.
- eng_done and eng_req in the same cycle: the request is still arbitrated that cycle; done_seen takes effect from the next cycle.
- Inputs outside RUN are ignored.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release with no start -> state IDLE, l_step=0, eng_rdy=0000, bram_we=0, all_done=0.
- Round-robin fairness: NUM_ENG=4, all four request reads continuously -> grants 0,1,2,3,0; each non-granted requester sees conflict=1; eng_rvalid one-hot trails the grant by 1 cycle; eng_rdata matches the BRAM preload at each granted address.
- Write path: only engine 2 requests, we=1, addr=0x015, wdata=0x0000_00A0 -> bram_we=1, bram_addr=0x015, bram_wdata=0xA0 in the same cycle; no conflict; no rvalid the next cycle; a later read of 0x015 returns 0xA0.
- Step barrier: engines assert eng_done at cycles 10, 14, 20, 25 -> one SYNC cycle at cycle 26 with eng_rdy=0; l_step goes 0->1; done_seen cleared; RUN resumes.
- Full run: MAX_STEPS=7, engines finish every step -> exactly 7 SYNC cycles; l_step ends at 6; all_done=1, busy=0. A new start restarts with l_step=0.
- Reset mid-operation: rst_n=0 during RUN at l_step=3 with grants in flight -> next cycle state IDLE, l_step=0, bram_we=0, eng_rvalid=0.
